apb_cmd_master: RTL and testbench

//  APB4 initiator (requester) converting a valid/ready command stream into single APB transfers on
//  the PCLK domain. Drives the FIFO/register slave's PSEL/PENABLE/PADDR side; returns read data and

---
 rtl/apb_cmd_master_pkg.sv | 29 ++
 rtl/apb_cmd_master.sv | 164 ++++++++++++++++
 tb/tb_apb_cmd_master.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/apb_cmd_master_pkg.sv
// apb_cmd_master_pkg: shared APB initiator types, widths and helpers
package apb_cmd_master_pkg;

    localparam int APB_PROT_W = 3;
    localparam int APB_ADDR_W = 32;
    localparam int APB_DATA_W = 32;

    typedef enum logic [1:0] {APB_IDLE, APB_SETUP, APB_ACCESS, APB_RESP} apb_state_e;

    typedef struct packed {
        logic                    write;
        logic [APB_ADDR_W-1:0]   addr;
        logic [APB_DATA_W-1:0]   wdata;
        logic [APB_DATA_W/8-1:0] strb;
        logic [APB_PROT_W-1:0]   prot;
    } apb_cmd_t;

    typedef struct packed {
        logic [APB_DATA_W-1:0] rdata;
        logic                  err;
        logic                  timeout;
    } apb_rsp_t;

    // Watchdog must hold TIMEOUT; keep at least one bit when the watchdog is disabled
    function automatic int wd_width(input int t);
        return (t < 1) ? 1 : $clog2(t + 1);
    endfunction

endpackage

// File: rtl/apb_cmd_master.sv
// apb_cmd_master: valid/ready command stream to single APB4 transfers, with PREADY watchdog
module apb_cmd_master
    import apb_cmd_master_pkg::*;
#(
    parameter int ADDR_W  = APB_ADDR_W,
    parameter int DATA_W  = APB_DATA_W,
    parameter int TIMEOUT = 16
) (
    input  logic                  PCLK,
    input  logic                  PRESETn,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_W-1:0]     cmd_addr,
    input  logic [DATA_W-1:0]     cmd_wdata,
    input  logic [DATA_W/8-1:0]   cmd_strb,
    input  logic [APB_PROT_W-1:0] cmd_prot,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic                  rsp_err,
    output logic                  rsp_timeout,
    output logic [ADDR_W-1:0]     PADDR,
    output logic [APB_PROT_W-1:0] PPROT,
    output logic                  PWRITE,
    output logic [DATA_W-1:0]     PWDATA,
    output logic [DATA_W/8-1:0]   PSTRB,
    output logic                  PSEL,
    output logic                  PENABLE,
    input  logic                  PREADY,
    input  logic                  PSLVERR,
    input  logic [DATA_W-1:0]     PRDATA
);

    localparam int STRB_W = DATA_W / 8;
    localparam int WD_W   = wd_width(TIMEOUT);
    localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT > 0 ? TIMEOUT - 1 : 0);
    localparam logic WD_EN = (TIMEOUT != 0);

    apb_state_e state_q, state_d;
    logic [WD_W-1:0] wd_q, wd_d;
    logic psel_q, psel_d, penable_q, penable_d, pwrite_q, pwrite_d;
    logic [ADDR_W-1:0] paddr_q, paddr_d;
    logic [DATA_W-1:0] pwdata_q, pwdata_d, rsp_rdata_q, rsp_rdata_d;
    logic [STRB_W-1:0] pstrb_q, pstrb_d;
    logic [APB_PROT_W-1:0] pprot_q, pprot_d;
    logic rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d, rsp_timeout_q, rsp_timeout_d;
    logic abort;

    assign abort = (state_q == APB_ACCESS) && !PREADY && WD_EN && (wd_q == WD_LIMIT);

    assign cmd_ready   = (state_q == APB_IDLE) && PRESETn;
    assign PSEL        = psel_q;
    assign PENABLE     = penable_q;
    assign PWRITE      = pwrite_q;
    assign PADDR       = paddr_q;
    assign PWDATA      = pwdata_q;
    assign PSTRB       = pstrb_q;
    assign PPROT       = pprot_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_err     = rsp_err_q;
    assign rsp_timeout = rsp_timeout_q;

    // State register; reset drops the transfer at once
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) state_q <= APB_IDLE;
        else          state_q <= state_d;
    end

    // Next-state: one SETUP cycle, ACCESS until PREADY or watchdog, RESP until consumed
    always_comb begin
        state_d = state_q;
        case (state_q)
            APB_IDLE:   state_d = cmd_valid ? APB_SETUP : APB_IDLE;
            APB_SETUP:  state_d = APB_ACCESS;
            APB_ACCESS: state_d = (PREADY || abort) ? APB_RESP : APB_ACCESS;
            APB_RESP:   state_d = rsp_ready ? APB_IDLE : APB_RESP;
            default:    state_d = APB_IDLE;
        endcase
    end

    // Output/datapath next values: latch command, drive phases, capture completion
    always_comb begin
        psel_d        = psel_q;
        penable_d     = penable_q;
        pwrite_d      = pwrite_q;
        paddr_d       = paddr_q;
        pwdata_d      = pwdata_q;
        pstrb_d       = pstrb_q;
        pprot_d       = pprot_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_err_d     = rsp_err_q;
        rsp_timeout_d = rsp_timeout_q;
        wd_d          = wd_q;
        case (state_q)
            APB_IDLE: begin
                if (cmd_valid) begin
                    psel_d    = 1'b1;
                    penable_d = 1'b0;
                    pwrite_d  = cmd_write;
                    paddr_d   = cmd_addr;
                    pwdata_d  = cmd_write ? cmd_wdata : '0;
                    pstrb_d   = cmd_write ? cmd_strb : '0;
                    pprot_d   = cmd_prot;
                    wd_d      = '0;
                end
            end
            APB_SETUP: penable_d = 1'b1;
            APB_ACCESS: begin
                if (PREADY || abort) begin
                    psel_d        = 1'b0;
                    penable_d     = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_rdata_d   = (PREADY && !pwrite_q) ? PRDATA : '0;
                    rsp_err_d     = PREADY ? PSLVERR : 1'b1;
                    rsp_timeout_d = !PREADY;
                end else begin
                    wd_d = (wd_q == '1) ? wd_q : wd_q + WD_W'(1);
                end
            end
            APB_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    wd_d        = '0;
                end
            end
            default: ;
        endcase
    end

    // Datapath registers
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            pwrite_q      <= 1'b0;
            paddr_q       <= '0;
            pwdata_q      <= '0;
            pstrb_q       <= '0;
            pprot_q       <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
            wd_q          <= '0;
        end else begin
            psel_q        <= psel_d;
            penable_q     <= penable_d;
            pwrite_q      <= pwrite_d;
            paddr_q       <= paddr_d;
            pwdata_q      <= pwdata_d;
            pstrb_q       <= pstrb_d;
            pprot_q       <= pprot_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_err_q     <= rsp_err_d;
            rsp_timeout_q <= rsp_timeout_d;
            wd_q          <= wd_d;
        end
    end

endmodule

// File: tb/tb_apb_cmd_master.sv
// tb_apb_cmd_master: table-driven and randomized checks of the APB command master
module tb_apb_cmd_master;
    import apb_cmd_master_pkg::*;

    localparam int TO = 16;

    logic        PCLK = 1'b0;
    logic        PRESETn = 1'b0;
    logic        cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
    logic [31:0] cmd_addr = '0, cmd_wdata = '0;
    logic [3:0]  cmd_strb = '0;
    logic [2:0]  cmd_prot = '0;
    logic        rsp_valid, rsp_ready = 1'b0, rsp_err, rsp_timeout;
    logic [31:0] rsp_rdata, PADDR, PWDATA, PRDATA = '0;
    logic [2:0]  PPROT;
    logic [3:0]  PSTRB;
    logic        PWRITE, PSEL, PENABLE, PREADY = 1'b0, PSLVERR = 1'b0;

    int checks = 0;
    int errors = 0;

    always #5 PCLK = ~PCLK;

    apb_cmd_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
        .PCLK(PCLK), .PRESETn(PRESETn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb), .cmd_prot(cmd_prot),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
        .PADDR(PADDR), .PPROT(PPROT), .PWRITE(PWRITE), .PWDATA(PWDATA), .PSTRB(PSTRB),
        .PSEL(PSEL), .PENABLE(PENABLE), .PREADY(PREADY), .PSLVERR(PSLVERR), .PRDATA(PRDATA)
    );

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [2:0]  prot;
        int          waits;
        logic        slverr;
        logic [31:0] prdata;
        int          rdly;
        logic [31:0] e_rdata;
        logic        e_err;
        logic        e_to;
        int          e_acc;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: a slave that stays not-ready for 'waits' cycles; the watchdog gives up after TO cycles
    function automatic vec_t model(input vec_t v);
        vec_t r = v;
        logic to = (TO != 0) && (v.waits >= TO);
        r.e_to    = to;
        r.e_err   = to || v.slverr;
        r.e_rdata = (to || v.wr) ? 32'h0 : v.prdata;
        r.e_acc   = to ? TO : v.waits + 1;
        return r;
    endfunction

    task automatic run(input vec_t v, input string tag);
        int j;
        logic [31:0] exp_wd;
        logic [3:0]  exp_st;
        exp_wd = v.wr ? v.wdata : 32'h0;
        exp_st = v.wr ? v.strb : 4'h0;
        cmd_valid = 1'b1; cmd_write = v.wr; cmd_addr = v.addr; cmd_wdata = v.wdata;
        cmd_strb = v.strb; cmd_prot = v.prot;
        PRDATA = v.prdata; PSLVERR = v.slverr; PREADY = 1'b0;
        j = 0;
        while (!cmd_ready && j < 20) begin
            @(negedge PCLK);
            j++;
        end
        chk({tag, ".cmd_ready_idle"}, cmd_ready, 1);
        @(negedge PCLK);
        cmd_valid = 1'b0; cmd_write = ~v.wr; cmd_addr = $urandom; cmd_wdata = $urandom;
        cmd_strb = 4'($urandom); cmd_prot = 3'($urandom);
        chk({tag, ".setup_ctl"}, {PSEL, PENABLE, PWRITE, cmd_ready}, {2'b10, v.wr, 1'b0});
        chk({tag, ".setup_addr"}, PADDR, v.addr);
        chk({tag, ".setup_wdata"}, PWDATA, exp_wd);
        chk({tag, ".setup_strb_prot"}, {PSTRB, PPROT}, {exp_st, v.prot});
        @(negedge PCLK);
        j = 1;
        while (j <= 40) begin
            chk({tag, ".access_ctl"}, {PSEL, PENABLE, PWRITE, PSTRB, PPROT}, {2'b11, v.wr, exp_st, v.prot});
            chk({tag, ".access_addr"}, PADDR, v.addr);
            chk({tag, ".access_wdata"}, PWDATA, exp_wd);
            PREADY = (j > v.waits);
            @(negedge PCLK);
            if (rsp_valid) break;
            j++;
        end
        PREADY = 1'b0;
        chk({tag, ".access_cycles"}, j, v.e_acc);
        chk({tag, ".done_ctl"}, {rsp_valid, PSEL, PENABLE}, 3'b100);
        chk({tag, ".rsp_rdata"}, rsp_rdata, v.e_rdata);
        chk({tag, ".rsp_err_to"}, {rsp_err, rsp_timeout}, {v.e_err, v.e_to});
        for (int k = 0; k < v.rdly; k++) begin
            cmd_valid = 1'b1;
            @(negedge PCLK);
            chk({tag, ".hold_ctl"}, {rsp_valid, cmd_ready, PSEL, PENABLE}, 4'b1000);
            chk({tag, ".hold_rsp"}, {rsp_rdata, rsp_err, rsp_timeout}, {v.e_rdata, v.e_err, v.e_to});
        end
        cmd_valid = 1'b0; rsp_ready = 1'b1;
        @(negedge PCLK);
        rsp_ready = 1'b0;
        chk({tag, ".back_idle"}, {rsp_valid, cmd_ready, PSEL}, 3'b010);
    endtask

    vec_t tbl[7];

    initial begin
        int setups;
        logic bad;
        vec_t v;
        tbl[0] = '{1'b1, 32'h4,  32'hDEADBEEF, 4'hF, 3'd0, 0,   1'b0, 32'h0,        0, 32'h0,        1'b0, 1'b0, 1};
        tbl[1] = '{1'b0, 32'h8,  32'hFFFF0000, 4'hF, 3'd2, 3,   1'b0, 32'h12345678, 0, 32'h12345678, 1'b0, 1'b0, 4};
        tbl[2] = '{1'b1, 32'hC,  32'h000055AA, 4'h3, 3'd1, 1,   1'b1, 32'h0,        1, 32'h0,        1'b1, 1'b0, 2};
        tbl[3] = '{1'b0, 32'h10, 32'h0,        4'h0, 3'd7, 100, 1'b0, 32'hCAFEF00D, 0, 32'h0,        1'b1, 1'b1, 16};
        tbl[4] = '{1'b1, 32'h20, 32'h01020304, 4'h8, 3'd4, 0,   1'b0, 32'h0,        5, 32'h0,        1'b0, 1'b0, 1};
        tbl[5] = '{1'b0, 32'h24, 32'h0,        4'h0, 3'd0, 15,  1'b0, 32'hA5A5A5A5, 2, 32'hA5A5A5A5, 1'b0, 1'b0, 16};
        tbl[6] = '{1'b0, 32'h28, 32'h0,        4'h0, 3'd3, 2,   1'b1, 32'h00000077, 0, 32'h00000077, 1'b1, 1'b0, 3};

        repeat (2) @(negedge PCLK);
        chk("reset_ctl", {PSEL, PENABLE, PWRITE, cmd_ready, rsp_valid, rsp_err, rsp_timeout}, 7'b0);
        chk("reset_addr_data", {PADDR, PWDATA}, 64'h0);
        chk("reset_strb_prot_rdata", {PSTRB, PPROT, rsp_rdata}, 39'h0);
        PRESETn = 1'b1;
        @(negedge PCLK);
        chk("idle_cmd_ready", cmd_ready, 1);

        for (int i = 0; i < 7; i++) run(tbl[i], $sformatf("vec%0d", i));

        // Back-to-back with zero-wait slave and always-ready consumer: one transfer per 4 cycles
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h30; rsp_ready = 1'b1; PREADY = 1'b1; PSLVERR = 1'b0;
        setups = 0; bad = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge PCLK);
            if (PSEL && !PENABLE) setups++;
            if ((PSEL && rsp_valid) || (PENABLE && !PSEL)) bad = 1'b1;
        end
        cmd_valid = 1'b0; rsp_ready = 1'b0; PREADY = 1'b0;
        chk("b2b_setups", setups, 3);
        chk("b2b_protocol", bad, 0);
        chk("b2b_end_idle", {cmd_ready, PSEL, rsp_valid}, 3'b100);

        // Reset asserted in the middle of ACCESS
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h40;
        @(negedge PCLK);
        cmd_valid = 1'b0;
        @(negedge PCLK);
        chk("rst_pre_access", {PSEL, PENABLE}, 2'b11);
        #2 PRESETn = 1'b0;
        #1 chk("rst_async_drop", {PSEL, PENABLE, rsp_valid, cmd_ready}, 4'b0);
        @(negedge PCLK);
        PRESETn = 1'b1;
        @(negedge PCLK);
        chk("rst_release_idle", {cmd_ready, PSEL, PENABLE, rsp_valid}, 4'b1000);

        // Randomized transfers against the reference model
        for (int i = 0; i < 40; i++) begin
            v.wr     = 1'($urandom);
            v.addr   = $urandom & 32'hFFFF_FFFC;
            v.wdata  = $urandom;
            v.strb   = 4'($urandom);
            v.prot   = 3'($urandom);
            v.waits  = ($urandom_range(0, 3) == 0) ? $urandom_range(14, 20) : $urandom_range(0, 4);
            v.slverr = ($urandom_range(0, 3) == 0);
            v.prdata = $urandom;
            v.rdly   = $urandom_range(0, 3);
            run(model(v), $sformatf("rnd%0d", i));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
